// File: rtl/jk_bank_driver.sv
// Drive side of a JK flip-flop bank: turns a target/mask request into a one-cycle
// J/K excitation pulse, then watches the bank feedback for completion or timeout.
module jk_bank_driver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMEOUT     = 4,
  parameter bit          TOGGLE_PREF = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_target,
  input  logic [WIDTH-1:0]           in_mask,
  input  logic [WIDTH-1:0]           q_fb,
  output logic [WIDTH-1:0]           j_out,
  output logic [WIDTH-1:0]           k_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] flips
);

  localparam int unsigned FW = $clog2(WIDTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] mask;
  logic [TW-1:0]    timer;

  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic [FW-1:0]    pop_c;
  logic             match_c;
  logic             expired_c;

  // Excitation for a fresh request, evaluated against the bank state at the accept edge
  always_comb begin
    diff_c = (q_fb ^ in_target) & in_mask;
    if (TOGGLE_PREF) begin
      j_c = diff_c;
      k_c = diff_c;
    end else begin
      j_c = diff_c & in_target;
      k_c = diff_c & ~in_target;
    end
    pop_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop_c = pop_c + FW'(diff_c[i]);
    end
  end

  assign match_c   = ((q_fb ^ target) & mask) == '0;
  assign expired_c = (timer == TW'(TIMEOUT - 1));

  // Request sequencer; all outputs registered so J/K are glitch-free at the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      mask     <= '0;
      timer    <= '0;
      j_out    <= '0;
      k_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      flips    <= '0;
      in_ready <= 1'b1;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            target   <= in_target;
            mask     <= in_mask;
            j_out    <= j_c;
            k_out    <= k_c;
            flips    <= pop_c;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          timer <= '0;
          state <= CHECK;
        end
        CHECK: begin
          // A match in the last allowed cycle still counts as success
          if (match_c) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else if (expired_c) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver: two instances (set/reset and toggle mode),
// each driving its own behavioural JK bank model.
module tb_jk_bank_driver;

  localparam int unsigned W  = 8;
  localparam int unsigned FW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_target = '0;
  logic [W-1:0]  in_mask = '0;

  logic          in_ready0, busy0, done0, err0;
  logic [W-1:0]  j0, k0, q0;
  logic [FW-1:0] flips0;
  logic          in_ready1, busy1, done1, err1;
  logic [W-1:0]  j1, k1, q1;
  logic [FW-1:0] flips1;

  logic          load_en = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          stuck = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .TIMEOUT(4), .TOGGLE_PREF(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_target(in_target), .in_mask(in_mask), .q_fb(q0),
    .j_out(j0), .k_out(k0), .busy(busy0), .done(done0), .err(err0), .flips(flips0)
  );

  jk_bank_driver #(.WIDTH(W), .TIMEOUT(4), .TOGGLE_PREF(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_target(in_target), .in_mask(in_mask), .q_fb(q1),
    .j_out(j1), .k_out(k1), .busy(busy1), .done(done1), .err(err1), .flips(flips1)
  );

  // Behavioural JK banks: Q+ = J&~Q | ~K&Q
  always @(posedge clk) begin
    if (load_en) begin
      q0 <= load_val;
      q1 <= load_val;
    end else if (stuck) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= (j0 & ~q0) | (~k0 & q0);
      q1 <= (j1 & ~q1) | (~k1 & q1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Present a request at a negedge; return at the negedge inside DRIVE
  task automatic send(input logic [W-1:0] t, input logic [W-1:0] m);
    in_target = t;
    in_mask   = m;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  int done_cyc[$];
  int drives;
  int errs;

  initial begin
    q0 = '0;
    q1 = '0;
    @(negedge clk);
    check("rst_j", 32'(j0), 32'h0);
    check("rst_ready", 32'(in_ready0), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready0), 32'h1);
    check("idle_busy", 32'(busy0), 32'h0);

    // Set/reset excitation
    load_bank(8'hA5);
    send(8'h5A, 8'hFF);
    check("sr_j", 32'(j0), 32'h5A);
    check("sr_k", 32'(k0), 32'hA5);
    check("sr_flips", 32'(flips0), 32'd8);
    check("sr_busy", 32'(busy0), 32'h1);
    check("sr_ready", 32'(in_ready0), 32'h0);
    @(negedge clk);
    check("sr_bank", 32'(q0), 32'h5A);
    check("sr_jk_off", 32'({j0, k0}), 32'h0);
    check("sr_nodone_early", 32'(done0), 32'h0);
    @(negedge clk);
    check("sr_done", 32'(done0), 32'h1);
    check("sr_err", 32'(err0), 32'h0);
    check("sr_ready_back", 32'(in_ready0), 32'h1);
    check("sr_busy_off", 32'(busy0), 32'h0);
    @(negedge clk);
    check("sr_done_pulse", 32'(done0), 32'h0);

    // Asynchronous reset in the middle of DRIVE
    load_bank(8'h00);
    send(8'hFF, 8'h0F);
    check("mid_j", 32'(j0), 32'h0F);
    #1 rst_n = 1'b0;
    #1;
    check("arst_j", 32'(j0), 32'h0);
    check("arst_k", 32'(k0), 32'h0);
    check("arst_flags", 32'({done0, err0, busy0}), 32'h0);
    check("arst_flips", 32'(flips0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(in_ready0), 32'h1);
    check("arst_bank", 32'(q0), 32'h00);

    // Masked hold
    load_bank(8'h00);
    send(8'hFF, 8'h0F);
    check("mh_j", 32'(j0), 32'h0F);
    check("mh_k", 32'(k0), 32'h00);
    check("mh_flips", 32'(flips0), 32'd4);
    @(negedge clk);
    check("mh_bank", 32'(q0), 32'h0F);
    @(negedge clk);
    check("mh_done", 32'(done0), 32'h1);
    @(negedge clk);

    // Toggle preference (dut1) against set/reset (dut0) on the same request
    load_bank(8'h3C);
    send(8'hC3, 8'hF0);
    check("tg_j", 32'(j1), 32'hF0);
    check("tg_k", 32'(k1), 32'hF0);
    check("tg_sr_j", 32'(j0), 32'hC0);
    check("tg_sr_k", 32'(k0), 32'h30);
    check("tg_flips", 32'(flips1), 32'd4);
    @(negedge clk);
    check("tg_bank", 32'(q1), 32'hCC);
    @(negedge clk);
    check("tg_done", 32'(done1), 32'h1);
    @(negedge clk);

    // Empty request still walks DRIVE and CHECK
    send(8'hCC, 8'hFF);
    check("em_jk", 32'({j0, k0}), 32'h0);
    check("em_flips", 32'(flips0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("em_done", 32'(done0), 32'h1);
    @(negedge clk);

    // Timeout with a stuck bank
    load_bank(8'h00);
    stuck = 1'b1;
    send(8'h01, 8'hFF);
    check("to_j", 32'(j0), 32'h01);
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (err0) errs++;
      check("to_quiet", 32'({done0, err0}), 32'h0);
    end
    @(negedge clk);
    check("to_err", 32'(err0), 32'h1);
    check("to_done", 32'(done0), 32'h0);
    check("to_ready", 32'(in_ready0), 32'h1);
    if (err0) errs++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (err0) errs++;
    end
    check("to_err_once", 32'(errs), 32'd1);
    stuck = 1'b0;

    // Back-to-back with in_valid held high
    load_bank(8'h00);
    in_target = 8'h11;
    in_mask   = 8'hFF;
    in_valid  = 1'b1;
    drives = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done0) done_cyc.push_back(c);
      if ((j0 | k0) != '0) begin
        drives++;
        if (drives == 1) begin
          check("bb_j1", 32'(j0), 32'h11);
          in_target = 8'h22;
        end else begin
          check("bb_j2", 32'(j0), 32'h22);
          check("bb_k2", 32'(k0), 32'h11);
          in_valid = 1'b0;
        end
      end
      if ((j0 | k0) != '0 && done0) check("bb_overlap", 32'h1, 32'h0);
      if (done0 && err0) check("bb_done_err", 32'h1, 32'h0);
    end
    in_valid = 1'b0;
    check("bb_drives", 32'(drives), 32'd2);
    check("bb_ndone", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) check("bb_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
    check("bb_bank", 32'(q0), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drive side of the JK flip-flop interface: accepts a target word and mask, computes per-bit J/K excitation from the current flop-bank state, and pulses J/K for exactly one clock.
- Then checks the bank feedback and reports completion or mismatch.
- Sits between control logic and a WIDTH-wide bank of JK flip-flops that share the same clock.

Parameters:
- WIDTH, 8, number of JK flip-flops driven.
- TIMEOUT, 4, maximum CHECK cycles to wait for the feedback to match before flagging an error (≥1).
- TOGGLE_PREF, 0, if 1 a changing bit is driven J=K=1 (toggle) instead of set/reset.

Ports:
- clk  input  1  rising-edge clock shared with the flop bank.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_target  input  WIDTH  desired next value of the bank.
- in_mask  input  WIDTH  1 = bit is updated, 0 = bit must hold.
- q_fb  input  WIDTH  Q outputs of the flop bank.
- j_out  output  WIDTH  J drive to the bank.
- k_out  output  WIDTH  K drive to the bank.
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  one-cycle pulse: masked bits of q_fb equal the target.
- err  output  1  one-cycle pulse: TIMEOUT expired without a match.
- flips  output  $clog2(WIDTH+1)  number of bits changed by the last accepted request.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - j_out=0, k_out=0, done=0, err=0, busy=0, flips=0.
  - in_ready=1 once reset is released.
  - Internal target/mask/timer regs cleared.
  - J/K are forced 0 immediately on reset assertion; no partial drive survives.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1, register in_target and in_mask, and compute excitation from q_fb sampled at that edge.
  - Next state DRIVE.
- Excitation, per bit i:
  - Mask=0 -> J=0, K=0 (hold).
  - Mask=1, q=t -> J=0, K=0.
  - Mask=1, q=0, t=1 -> J=1, K=0; J=K=1 if TOGGLE_PREF.
  - Mask=1, q=1, t=0 -> J=0, K=1; J=K=1 if TOGGLE_PREF.
  - J=K=1 is never issued with TOGGLE_PREF=0.
- flips:
  - Updated at the accept edge to popcount((q_fb ^ in_target) & in_mask).
  - Result has width $clog2(WIDTH+1); held until the next accept.
- DRIVE:
  - Lasts exactly 1 cycle; j_out/k_out are registered outputs valid during this cycle only.
  - The bank samples them at the closing edge.
  - Next state CHECK, with timer=0.
  - j_out/k_out return to 0 in every state other than DRIVE.
- CHECK:
  - Each cycle compare (q_fb & mask) with (target & mask).
  - Match -> done=1 for one cycle, next state IDLE.
  - Otherwise timer increments; when timer reaches TIMEOUT-1 with no match -> err=1 for one cycle, next state IDLE.
  - Match and timeout in the same cycle -> done wins; err stays 0.
- Latency: for an ideal bank, accept edge N -> DRIVE in cycle N+1 -> match in cycle N+2 -> done visible in cycle N+3.
- in_ready:
  - Low in DRIVE and CHECK; in_valid is ignored while low.
  - The requester holds in_valid until it sees in_ready=1 at the edge.
  - Back-to-back: in_ready returns to 1 in the cycle done/err is asserted, so the next accept can occur at the edge ending that cycle.
- Empty request (mask=0 or target already equal):
  - Still passes DRIVE (J=K=0) and CHECK.
  - done fires; flips=0.
- done and err are never high together.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE with j_out=8'h0F -> j_out, k_out, done, err, busy, flips all 0 immediately; state IDLE; in_ready=1 after release.
- Set/reset, WIDTH=8, TOGGLE_PREF=0, bank model Q=8'hA5, target=8'h5A, mask=8'hFF:
  - DRIVE cycle: j_out=8'h5A, k_out=8'hA5.
  - flips=8.
  - Bank becomes 8'h5A and done pulses 2 cycles after DRIVE.
- Masked hold: Q=8'h00, target=8'hFF, mask=8'h0F -> j_out=8'h0F, k_out=8'h00; bank=8'h0F; done pulses; flips=4.
- Toggle mode, TOGGLE_PREF=1: Q=8'h3C, target=8'hC3, mask=8'hF0 -> j_out=k_out=8'hF0; bank=8'hCC; done pulses.
- Timeout, TIMEOUT=4: bank model stuck at 8'h00, target=8'h01 -> no done; err pulses exactly once after 4 CHECK cycles; in_ready=1 in that cycle.
- Back-to-back: in_valid held high with two queued targets 8'h11 then 8'h22 -> second accepted at the edge ending the first done cycle; no overlap of j/k drive; two done pulses 3 cycles apart.
